// File: rtl/lab08_win_mac.sv
// Pair-in / byte-out responder: 4-deep sliding-window sum of per-pair products.
// Build option LAB08_WIN_PIPE_EN adds one register stage between multiplier and adder.
module lab08_win_mac (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [2:0] in_data1,
    input  logic [2:0] in_data2,
    output logic       out_valid,
    output logic [7:0] out_data
);

    logic [5:0] prod_q, prod_d;
    logic       prod_vld_q, prod_vld_d;

    logic [5:0] win_p;
    logic       win_vld;

    logic [5:0] w0_q, w0_d;
    logic [5:0] w1_q, w1_d;
    logic [5:0] w2_q, w2_d;
    logic       out_valid_q, out_valid_d;
    logic [7:0] out_data_q, out_data_d;

    always_comb begin
        prod_vld_d = in_valid;
        prod_d     = in_valid ? ({3'b000, in_data1} * {3'b000, in_data2}) : 6'd0;
    end

`ifdef LAB08_WIN_PIPE_EN
    logic [5:0] pipe_q, pipe_d;
    logic       pipe_vld_q, pipe_vld_d;

    always_comb begin
        pipe_vld_d = prod_vld_q;
        pipe_d     = prod_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pipe_vld_q <= 1'b0;
            pipe_q     <= 6'd0;
        end else begin
            pipe_vld_q <= pipe_vld_d;
            pipe_q     <= pipe_d;
        end
    end

    assign win_p   = pipe_q;
    assign win_vld = pipe_vld_q;
`else
    assign win_p   = prod_q;
    assign win_vld = prod_vld_q;
`endif

    // An idle slot reaching the window ends the burst: history is wiped, output forced to 0.
    always_comb begin
        out_valid_d = win_vld;
        out_data_d  = 8'd0;
        w0_d        = 6'd0;
        w1_d        = 6'd0;
        w2_d        = 6'd0;
        if (win_vld) begin
            out_data_d = {2'b00, win_p} + {2'b00, w0_q} + {2'b00, w1_q} + {2'b00, w2_q};
            w0_d       = win_p;
            w1_d       = w0_q;
            w2_d       = w1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prod_vld_q  <= 1'b0;
            prod_q      <= 6'd0;
            w0_q        <= 6'd0;
            w1_q        <= 6'd0;
            w2_q        <= 6'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'd0;
        end else begin
            prod_vld_q  <= prod_vld_d;
            prod_q      <= prod_d;
            w0_q        <= w0_d;
            w1_q        <= w1_d;
            w2_q        <= w2_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule
